// File: rtl/qns_pkg.sv
// Shared quantiser/noise-shaper constants: default datapath sizing and saturation limits.
package qns_pkg;

   localparam int unsigned IN_W  = 19;
   localparam int unsigned R     = 32;
   localparam int unsigned N     = 3;
   localparam int unsigned LOG2R = $clog2(R);
   localparam int unsigned ACC_W = IN_W + N * LOG2R;

   // Two's-complement limits of a w-bit sample.
   function automatic longint sat_hi(input int unsigned w);
      return (longint'(1) << (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int unsigned w);
      return -(longint'(1) << (w - 1));
   endfunction

   localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(sat_hi(IN_W));
   localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(sat_lo(IN_W));

endpackage

// File: rtl/mod2_cic_interp_x32_if.sv
// Low-rate sample handshake in, high-rate sample stream and status out.
interface mod2_cic_interp_x32_if #(
   parameter int unsigned IN_W = qns_pkg::IN_W
);
   logic signed [IN_W-1:0] in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic signed [IN_W-1:0] out;
   logic                   out_strobe;
   logic                   underrun;

   modport master (
      output in_data, in_valid,
      input  in_ready, out, out_strobe, underrun
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, out, out_strobe, underrun
   );
endinterface

// File: rtl/cic_int_stage.sv
// One CIC integrator: W-bit accumulator, wraps modulo 2^W, advances only when enabled.
module cic_int_stage #(
   parameter int unsigned W = qns_pkg::ACC_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_en,
   input  logic signed [W-1:0] i_din,
   output logic signed [W-1:0] o_acc
);

   logic signed [W-1:0] r_acc;

   always_ff @(posedge clock) begin
      if (reset)
         r_acc <= '0;
      else if (i_en)
         r_acc <= r_acc + i_din;
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/mod2_cic_interp_x32.sv
// x32 CIC interpolator (N combs at the low rate, N integrators at the clock rate) feeding mod2.
module mod2_cic_interp_x32 #(
   parameter int unsigned IN_W = qns_pkg::IN_W,
   parameter int unsigned R    = qns_pkg::R,
   parameter int unsigned N    = qns_pkg::N
) (
   input  logic                 clock,
   input  logic                 reset,
   mod2_cic_interp_x32_if.slave bus
);

   localparam int unsigned LOG2R = $clog2(R);
   localparam int unsigned ACC_W = IN_W + N * LOG2R;
   localparam int unsigned SHIFT = (N - 1) * LOG2R;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(qns_pkg::sat_hi(IN_W));
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(qns_pkg::sat_lo(IN_W));

   logic [LOG2R-1:0]       r_phase;
   logic                   w_phase0;
   logic                   w_phase1;

   logic signed [ACC_W-1:0] w_comb   [0:N];
   logic signed [ACC_W-1:0] r_comb_z [0:N-1];
   logic signed [ACC_W-1:0] r_cn;
   logic signed [ACC_W-1:0] w_int    [0:N];

   logic signed [ACC_W-1:0] w_shr;
   logic signed [IN_W-1:0]  w_sat;
   logic signed [IN_W-1:0]  r_out;
   logic                    r_strobe;
   logic                    r_underrun;

   assign w_phase0 = (r_phase == '0);
   assign w_phase1 = (r_phase == LOG2R'(1));

   // A missing sample in its slot is replaced by zero.
   assign w_comb[0] = bus.in_valid ? ACC_W'(bus.in_data) : '0;

   for (genvar k = 0; k < N; k++) begin : g_comb
      assign w_comb[k+1] = w_comb[k] - r_comb_z[k];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase    <= '0;
         r_cn       <= '0;
         r_out      <= '0;
         r_strobe   <= 1'b0;
         r_underrun <= 1'b0;
         for (int k = 0; k < N; k++)
            r_comb_z[k] <= '0;
      end else begin
         r_phase  <= r_phase + LOG2R'(1);
         r_strobe <= w_phase1;
         r_out    <= w_sat;
         if (w_phase0) begin
            for (int k = 0; k < N; k++)
               r_comb_z[k] <= w_comb[k];
            r_cn <= w_comb[N];
            if (!bus.in_valid)
               r_underrun <= 1'b1;
         end
      end
   end

   // Zero-stuffing: the first integrator only sees the comb output on the phase-1 edge.
   assign w_int[0] = r_cn;

   for (genvar k = 0; k < N; k++) begin : g_int
      if (k == 0) begin : g_first
         cic_int_stage #(.W(ACC_W)) u_int (
            .clock (clock),
            .reset (reset),
            .i_en  (w_phase1),
            .i_din (w_int[k]),
            .o_acc (w_int[k+1])
         );
      end else begin : g_rest
         cic_int_stage #(.W(ACC_W)) u_int (
            .clock (clock),
            .reset (reset),
            .i_en  (1'b1),
            .i_din (w_int[k]),
            .o_acc (w_int[k+1])
         );
      end
   end

   // Remove the R^(N-1) CIC gain, then clamp to the output range.
   assign w_shr = w_int[N] >>> SHIFT;

   always_comb begin
      w_sat = IN_W'(w_shr);
      if (w_shr > SAT_HI)
         w_sat = IN_W'(SAT_HI);
      else if (w_shr < SAT_LO)
         w_sat = IN_W'(SAT_LO);
   end

   assign bus.in_ready   = w_phase0 && !reset;
   assign bus.out        = r_out;
   assign bus.out_strobe = r_strobe;
   assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_mod2_cic_interp_x32.sv
// Bench for mod2_cic_interp_x32: per-cycle comparison against a convolution model plus directed scenarios.
module tb_mod2_cic_interp_x32;

   localparam int IN_W  = 19;
   localparam int R     = 32;
   localparam int N     = 3;
   localparam int SHIFT = 10;
   localparam int LAT   = 4;
   localparam int HLEN  = N * (R - 1) + 1;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   mod2_cic_interp_x32_if #(.IN_W(IN_W)) bus ();

   mod2_cic_interp_x32 #(.IN_W(IN_W), .R(R), .N(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: CIC impulse response, history of accepted samples (newest first), phase, flags.
   longint h [];
   longint hist [$];
   longint obs [$];
   int     m_phase  = 0;
   bit     m_under  = 1'b0;
   bit     m_strobe = 1'b0;
   longint m_out    = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
   endtask

   // High-rate output = zero-stuffed input convolved with the box^N response, scaled and clamped.
   function automatic longint model_out();
      longint acc = 0;
      for (int j = 0; j < HLEN; j++)
         if (LAT + j < hist.size())
            acc += hist[LAT + j] * h[j];
      acc = acc >>> SHIFT;
      if (acc > 262143)  acc = 262143;
      if (acc < -262144) acc = -262144;
      return acc;
   endfunction

   task automatic step(input bit rst, input bit vld, input longint d);
      logic signed [IN_W-1:0] dd;
      dd = IN_W'(d);
      reset        = rst;
      bus.in_valid = vld;
      bus.in_data  = dd;
      #1;
      chk("in_ready", longint'(bus.in_ready), longint'(!rst && m_phase == 0));
      @(posedge clock);
      #1;
      if (rst) begin
         hist.delete();
         m_phase  = 0;
         m_under  = 1'b0;
         m_strobe = 1'b0;
      end else begin
         if (m_phase == 0) begin
            hist.push_front(vld ? longint'(dd) : 0);
            if (!vld) m_under = 1'b1;
         end else begin
            hist.push_front(0);
         end
         m_strobe = (m_phase == 1);
         m_phase  = (m_phase + 1) % R;
         while (hist.size() > HLEN + LAT) void'(hist.pop_back());
      end
      m_out = model_out();
      chk("out", longint'(bus.out), m_out);
      chk("out_strobe", longint'(bus.out_strobe), longint'(m_strobe));
      chk("underrun", longint'(bus.underrun), longint'(m_under));
      obs.push_back(longint'(bus.out));
   endtask

   // One low-rate slot starting at phase 0; optional junk on in_valid at the other phases.
   task automatic slot(input bit vld, input longint d, input bit noise);
      for (int c = 0; c < R; c++) begin
         if (m_phase == 0)
            step(1'b0, vld, d);
         else
            step(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, longint'($signed(IN_W'($urandom))));
      end
   endtask

   task automatic do_reset(input int cycles);
      for (int c = 0; c < cycles; c++)
         step(1'b1, 1'b0, 0);
      obs.delete();
   endtask

   task automatic check_settle(input string tag, input int from, input int upto, input longint val);
      int bad = 0;
      for (int i = from; i <= upto; i++)
         if (obs[i] != val) bad++;
      chk(tag, bad, 0);
   endtask

   initial begin
      longint nxt [];
      longint sum;
      int     viol;

      h = new[1];
      h[0] = 1;
      repeat (N) begin
         nxt = new[h.size() + R - 1];
         for (int i = 0; i < h.size(); i++)
            for (int k = 0; k < R; k++)
               nxt[i + k] += h[i];
         h = nxt;
      end

      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // Reset state
      do_reset(3);
      chk("rst_out", longint'(bus.out), 0);
      chk("rst_strobe", longint'(bus.out_strobe), 0);
      chk("rst_underrun", longint'(bus.underrun), 0);

      // Impulse of 1024: response starts 0,1,3,6 and sums to 32768
      slot(1'b1, 1024, 1'b1);
      for (int s = 0; s < N + 1; s++) slot(1'b1, 0, 1'b1);
      chk("imp_t3", obs[3], 0);
      chk("imp_t4", obs[4], 1);
      chk("imp_t5", obs[5], 3);
      chk("imp_t6", obs[6], 6);
      sum = 0;
      foreach (obs[i]) sum += obs[i];
      chk("imp_sum", sum, 32768);

      // Positive and negative steps
      do_reset(2);
      for (int s = 0; s < 5; s++) slot(1'b1, 1000, 1'b1);
      viol = 0;
      for (int i = 1; i < obs.size(); i++) if (obs[i] < obs[i-1]) viol++;
      chk("step_pos_mono", viol, 0);
      check_settle("step_pos_settle", 100, obs.size() - 1, 1000);

      do_reset(2);
      for (int s = 0; s < 5; s++) slot(1'b1, -1000, 1'b0);
      viol = 0;
      for (int i = 1; i < obs.size(); i++) if (obs[i] > obs[i-1]) viol++;
      chk("step_neg_mono", viol, 0);
      check_settle("step_neg_settle", 100, obs.size() - 1, -1000);

      // Full scale both ways, no wrap
      do_reset(2);
      for (int s = 0; s < 5; s++) slot(1'b1, 262143, 1'b1);
      check_settle("fs_pos_settle", 100, obs.size() - 1, 262143);
      obs.delete();
      for (int s = 0; s < 5; s++) slot(1'b1, -262144, 1'b1);
      check_settle("fs_neg_settle", 100, obs.size() - 1, -262144);

      // Underrun is sticky; in_valid at phase 5 is ignored with in_ready low
      do_reset(2);
      for (int s = 0; s < 3; s++) slot(1'b1, 5000, 1'b0);
      chk("under_before", longint'(bus.underrun), 0);
      slot(1'b0, 0, 1'b0);
      chk("under_set", longint'(bus.underrun), 1);
      while (m_phase != 5) step(1'b0, 1'b0, 0);
      bus.in_valid = 1'b1;
      #1;
      chk("ready_ph5", longint'(bus.in_ready), 0);
      step(1'b0, 1'b1, 77777);
      while (m_phase != 0) step(1'b0, 1'b0, 0);
      for (int s = 0; s < 2; s++) slot(1'b1, 5000, 1'b0);
      chk("under_stays", longint'(bus.underrun), 1);

      // Mid-run reset during a ramp
      do_reset(2);
      for (int s = 0; s < 4; s++) slot(1'b1, longint'(s * 3000 - 4000), 1'b1);
      for (int c = 0; c < 13; c++) step(1'b0, 1'b1, longint'(c * 11));
      step(1'b1, 1'b1, 1234);
      step(1'b1, 1'b1, 1234);
      chk("mid_rst_out", longint'(bus.out), 0);
      chk("mid_rst_strobe", longint'(bus.out_strobe), 0);
      chk("mid_rst_underrun", longint'(bus.underrun), 0);
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", longint'(bus.in_ready), 1);
      for (int s = 0; s < 4; s++) slot(1'b1, longint'(s * 500), 1'b1);

      // Random traffic with occasional missing samples and resets
      for (int c = 0; c < 4000; c++) begin
         bit rst;
         bit vld;
         rst = ($urandom_range(0, 599) == 0);
         vld = (m_phase == 0) ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
         step(rst, vld, longint'($signed(IN_W'($urandom))));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
